// File: rtl/key_insn_pkg.sv
// Shared constants for the key-to-instruction generator: instruction words,
// key indices and the acknowledge-handshake state encoding.
package key_insn_pkg;

  localparam logic [31:0] INSN_LEFT  = 32'h2842_0001;  // addi r2,r2,1
  localparam logic [31:0] INSN_RIGHT = 32'h2842_FFFF;  // addi r2,r2,-1
  localparam logic [31:0] INSN_FIRE  = 32'h2863_0001;  // addi r3,r3,1

  // Bit positions inside key_level / pending vectors: {left, right, fire}
  localparam int KEY_FIRE  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_LEFT  = 2;
  localparam int NUM_KEYS  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VALID    = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_e;

endpackage

// File: rtl/key_insn_gen_if.sv
// Instruction hand-off bundle between the key generator (master) and the
// processor side (slave) that acknowledges with a level signal.
interface key_insn_gen_if;
  logic [31:0] insn_key;
  logic        key_pressed;
  logic        key_ack;

  modport master (output insn_key, output key_pressed, input key_ack);
  modport slave  (input insn_key, input key_pressed, output key_ack);
endinterface

// File: rtl/key_debounce.sv
// One button: 2-flop synchronizer, stability counter, debounced level and a
// one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_n,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          pressed;

  assign pressed = ~sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;  // released
      cnt_q  <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_raw_n};
      rise   <= 1'b0;
      if (pressed == level) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        cnt_q <= '0;
        level <= pressed;
        rise  <= pressed;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end
endmodule

// File: rtl/key_insn_gen.sv
// Debounced buttons -> instruction words with a 4-phase level handshake.
// Define KEY_AUTOREPEAT_EN to auto-repeat held left/right keys.
module key_insn_gen
  import key_insn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic        clk_in,
  input  logic        reset_SW1,
  input  logic        KEY3,
  input  logic        KEY2,
  input  logic        KEY1,
  input  logic        key_ack,
  output logic [31:0] insn_key,
  output logic        key_pressed,
  output logic [2:0]  key_level
);
  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("key_insn_gen: cycle parameters must be >= 1");
  end

  logic [NUM_KEYS-1:0] raw_n, level, rise, rpt_set, pend_q, pend_clr;
  logic [1:0]          ack_q;
  logic                ack_sync;
  hs_state_e           state_q, state_d;
  logic [31:0]         insn_q, insn_d;

  assign raw_n[KEY_LEFT]  = KEY3;
  assign raw_n[KEY_RIGHT] = KEY2;
  assign raw_n[KEY_FIRE]  = KEY1;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk_in),
      .rst_n    (reset_SW1),
      .key_raw_n(raw_n[k]),
      .level    (level[k]),
      .rise     (rise[k])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_rpt
    if (k == KEY_FIRE) begin : g_none
      assign rpt_set[k] = 1'b0;
    end else begin : g_timer
      logic [RW-1:0] tmr_q;
      // Timer restarts at the press event so repeats land every REPEAT_CYCLES after it
      always_ff @(posedge clk_in or negedge reset_SW1) begin
        if (!reset_SW1)                       tmr_q <= '0;
        else if (!level[k] || rise[k])        tmr_q <= '0;
        else if (tmr_q == RPT_LAST)           tmr_q <= '0;
        else                                  tmr_q <= tmr_q + RW'(1);
      end
      assign rpt_set[k] = level[k] && !rise[k] && (tmr_q == RPT_LAST);
    end
  end
`else
  assign rpt_set = '0;
`endif

  always_ff @(posedge clk_in or negedge reset_SW1) begin
    if (!reset_SW1) begin
      ack_q   <= 2'b00;
      pend_q  <= '0;
      state_q <= IDLE;
      insn_q  <= '0;
    end else begin
      ack_q   <= {ack_q[0], key_ack};
      // A new press wins over the clear of the same bit
      pend_q  <= (pend_q & ~pend_clr) | rise | rpt_set;
      state_q <= state_d;
      insn_q  <= insn_d;
    end
  end

  assign ack_sync = ack_q[1];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    pend_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d = VALID;
          if (pend_q[KEY_FIRE]) begin
            insn_d             = INSN_FIRE;
            pend_clr[KEY_FIRE] = 1'b1;
          end else if (pend_q[KEY_LEFT]) begin
            insn_d             = INSN_LEFT;
            pend_clr[KEY_LEFT] = 1'b1;
          end else begin
            insn_d              = INSN_RIGHT;
            pend_clr[KEY_RIGHT] = 1'b1;
          end
        end
      end
      VALID: begin
        if (ack_sync) begin
          state_d = WAIT_LOW;
          insn_d  = '0;
        end
      end
      WAIT_LOW: begin
        if (!ack_sync) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        insn_d  = '0;
      end
    endcase
  end

  assign key_pressed = (state_q == VALID);
  assign insn_key    = insn_q;
  assign key_level   = level;
endmodule

// File: tb/tb_key_insn_gen.sv
// Directed bench for key_insn_gen with short debounce/repeat periods and a
// processor-side ack model that echoes key_pressed three cycles late.
module tb_key_insn_gen;
  import key_insn_pkg::*;

  localparam int DEB = 4;
  localparam int RPT = 16;
`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP_HELD_EVENTS = 4;
`else
  localparam int EXP_HELD_EVENTS = 1;
`endif

  logic       clk_in    = 1'b0;
  logic       reset_SW1 = 1'b0;
  logic       KEY3 = 1'b1, KEY2 = 1'b1, KEY1 = 1'b1;
  logic [2:0] key_level;

  key_insn_gen_if bus ();

  key_insn_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(RPT)) dut (
    .clk_in     (clk_in),
    .reset_SW1  (reset_SW1),
    .KEY3       (KEY3),
    .KEY2       (KEY2),
    .KEY1       (KEY1),
    .key_ack    (bus.key_ack),
    .insn_key   (bus.insn_key),
    .key_pressed(bus.key_pressed),
    .key_level  (key_level)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Processor model: ack follows key_pressed three cycles late unless blocked
  logic [2:0] kp_hist   = 3'b000;
  logic       ack_block = 1'b0;
  always @(negedge clk_in) begin
    kp_hist     = {kp_hist[1:0], bus.key_pressed};
    bus.key_ack = !ack_block && kp_hist[2];
  end

  // Event log plus protocol watchers
  logic [31:0] ev_insn[$];
  int          ev_cyc[$];
  logic        kp_prev   = 1'b0;
  logic [31:0] insn_prev = '0;
  logic        insn_bad  = 1'b0;
  logic [2:0]  level_or  = 3'b000;
  always @(negedge clk_in) begin
    if (bus.key_pressed && !kp_prev) begin
      ev_insn.push_back(bus.insn_key);
      ev_cyc.push_back(cyc);
    end
    if (!bus.key_pressed && bus.insn_key != 32'h0) insn_bad = 1'b1;
    if (bus.key_pressed && kp_prev && bus.insn_key != insn_prev) insn_bad = 1'b1;
    level_or  = level_or | key_level;
    kp_prev   = bus.key_pressed;
    insn_prev = bus.insn_key;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_events(input int n, input int budget);
    int t = 0;
    while (ev_insn.size() < n && t < budget) begin
      @(negedge clk_in);
      t++;
    end
  endtask

  task automatic clear_log();
    ev_insn.delete();
    ev_cyc.delete();
    insn_bad = 1'b0;
    level_or = 3'b000;
  endtask

  function automatic logic [31:0] ev_at(input int i);
    return (ev_insn.size() > i) ? ev_insn[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int gap_at(input int i);
    return (ev_cyc.size() > i + 1) ? ev_cyc[i+1] - ev_cyc[i] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    // Reset state
    cycles(3);
    check("rst_pressed", {31'b0, bus.key_pressed}, 32'h0);
    check("rst_insn", bus.insn_key, 32'h0);
    check("rst_level", {29'b0, key_level}, 32'h0);
    reset_SW1 = 1'b1;
    cycles(2);

    // Clean fire press: event at edge DEB+4, one event only
    clear_log();
    t0   = cyc;
    KEY1 = 1'b0;
    wait_events(1, 40);
    check("fire_latency", (ev_cyc.size() > 0) ? ev_cyc[0] - t0 : -1, 8);
    check("fire_insn", ev_at(0), INSN_FIRE);
    check("fire_level", {29'b0, key_level}, 32'h1);
    cycles(20);
    KEY1 = 1'b1;
    cycles(20);
    check("fire_count", ev_insn.size(), 1);
    check("fire_idle", {31'b0, bus.key_pressed}, 32'h0);
    check("fire_release_level", {29'b0, key_level}, 32'h0);
    check("fire_insn_rules", {31'b0, insn_bad}, 32'h0);

    // Bouncing left key never settles long enough
    clear_log();
    repeat (5) begin
      KEY3 = 1'b0; cycles(2);
      KEY3 = 1'b1; cycles(2);
    end
    cycles(30);
    check("bounce_count", ev_insn.size(), 0);
    check("bounce_level", {29'b0, level_or}, 32'h0);

    // Simultaneous left + fire: fire first, left after the 4-phase handshake
    clear_log();
    KEY3 = 1'b0;
    KEY1 = 1'b0;
    wait_events(1, 40);
    KEY3 = 1'b1;
    KEY1 = 1'b1;
    wait_events(2, 60);
    check("pair_first", ev_at(0), INSN_FIRE);
    check("pair_second", ev_at(1), INSN_LEFT);
    check("pair_gap", gap_at(0), 11);
    cycles(30);
    check("pair_count", ev_insn.size(), 2);

    // Right pressed while fire waits 50 cycles for ack
    clear_log();
    ack_block = 1'b1;
    KEY1 = 1'b0;
    wait_events(1, 40);
    KEY2 = 1'b0;
    cycles(50);
    check("hold_pressed", {31'b0, bus.key_pressed}, 32'h1);
    check("hold_insn", bus.insn_key, INSN_FIRE);
    check("hold_count", ev_insn.size(), 1);
    KEY1 = 1'b1;
    KEY2 = 1'b1;
    ack_block = 1'b0;
    wait_events(2, 60);
    check("hold_right", ev_at(1), INSN_RIGHT);
    cycles(30);
    check("hold_total", ev_insn.size(), 2);
    check("hold_insn_rules", {31'b0, insn_bad}, 32'h0);

    // Left held 60 cycles
    clear_log();
    KEY3 = 1'b0;
    cycles(60);
    KEY3 = 1'b1;
    cycles(40);
    check("held_count", ev_insn.size(), EXP_HELD_EVENTS);
    check("held_first", ev_at(0), INSN_LEFT);
    for (int i = 1; i < ev_insn.size(); i++) begin
      check("held_kind", ev_insn[i], INSN_LEFT);
      check("held_spacing", gap_at(i - 1), RPT);
    end

    // Reset during VALID drops the event; released key is not replayed
    clear_log();
    ack_block = 1'b1;
    KEY1 = 1'b0;
    wait_events(1, 40);
    KEY1 = 1'b1;
    cycles(2);
    #2 reset_SW1 = 1'b0;
    #1;
    check("rstv_pressed", {31'b0, bus.key_pressed}, 32'h0);
    check("rstv_insn", bus.insn_key, 32'h0);
    cycles(2);
    reset_SW1 = 1'b1;
    ack_block = 1'b0;
    cycles(40);
    check("rstv_no_replay", ev_insn.size(), 1);

    // Fire held across reset deassertion yields exactly one event
    clear_log();
    KEY1 = 1'b0;
    cycles(3);
    reset_SW1 = 1'b0;
    cycles(2);
    reset_SW1 = 1'b1;
    cycles(40);
    check("held_rst_count", ev_insn.size(), 1);
    check("held_rst_insn", ev_at(0), INSN_FIRE);
    KEY1 = 1'b1;
    cycles(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
